// File: rtl/exp_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : exp_req_arbiter
// Description : Round-robin arbiter/sequencer sharing one exponential core
//               among N requesters. One operation in flight at a time:
//               accept operand, load core, wait for result or timeout,
//               return the tagged response.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_req_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [32*N-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    output logic              core_load,
    output logic [31:0]       core_operand,
    output logic              core_start,
    input  logic              core_input_ready,
    input  logic              core_done,
    input  logic [31:0]       core_result,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam logic [1:0]     S_IDLE     = 2'd0;
    localparam logic [1:0]     S_LOAD     = 2'd1;
    localparam logic [1:0]     S_WAIT     = 2'd2;
    localparam logic [1:0]     S_RESP     = 2'd3;
    localparam logic [7:0]     C_TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [IDW-1:0] C_LAST_ID  = IDW'(N - 1);
    localparam logic [IDW:0]   C_N_EXT    = (IDW+1)'(N);

    logic [1:0]     r_state;
    logic [1:0]     w_next_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_gnt_id;
    logic [7:0]     r_timer;
    logic [31:0]    r_operand;
    logic [31:0]    r_rsp_data;
    logic           r_rsp_err;

    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [IDW:0]   w_idx;
    logic [31:0]    w_win_data;
    logic           w_accept;
    logic           w_timeout;

    // Rotating priority search: first valid requester at or after r_ptr
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= C_N_EXT) begin
                w_idx = w_idx - C_N_EXT;
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[IDW-1:0];
            end
        end
    end

    assign w_win_data = req_data[{w_winner, 5'b00000} +: 32];
    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign w_timeout  = (r_timer == C_TMO_LAST);

    // State register
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_found)                  w_next_state = S_LOAD;
            S_LOAD:  if (core_input_ready)         w_next_state = S_WAIT;
            S_WAIT:  if (core_done || w_timeout)   w_next_state = S_RESP;
            S_RESP:  if (rsp_ready)                w_next_state = S_IDLE;
            default:                               w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand/grant capture, WAIT timer, result capture, pointer
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_ptr      <= '0;
            r_gnt_id   <= '0;
            r_timer    <= '0;
            r_operand  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_operand <= w_win_data;
                r_gnt_id  <= w_winner;
            end
            if ((r_state == S_LOAD) && core_input_ready) begin
                r_timer <= '0;
            end
            if (r_state == S_WAIT) begin
                r_timer <= r_timer + 8'd1;
                // A result landing on the timeout cycle still counts as success
                if (core_done) begin
                    r_rsp_data <= core_result;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                end
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_ptr <= (r_gnt_id == C_LAST_ID) ? '0 : r_gnt_id + IDW'(1);
            end
        end
    end

    // Output decode from the state register; req_ready is the only path from inputs
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
        core_load    = (r_state == S_LOAD);
        core_start   = (r_state == S_WAIT);
        rsp_valid    = (r_state == S_RESP);
        busy         = (r_state != S_IDLE);
        core_operand = r_operand;
        rsp_id       = r_gnt_id;
        rsp_data     = r_rsp_data;
        rsp_err      = r_rsp_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_req_arbiter
// Description : Self-checking bench for exp_req_arbiter with a scoreboard
//               of expected responses and a behavioural core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_req_arbiter;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;

    logic             CLK = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [32*N-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic             core_load;
    logic [31:0]      core_operand;
    logic             core_start;
    logic             core_input_ready;
    logic             core_done;
    logic [31:0]      core_result;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             rsp_ready;
    logic             busy;

    exp_req_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) u_dut (
        .CLK              (CLK),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .core_load        (core_load),
        .core_operand     (core_operand),
        .core_start       (core_start),
        .core_input_ready (core_input_ready),
        .core_done        (core_done),
        .core_result      (core_result),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .rsp_ready        (rsp_ready),
        .busy             (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ptr_m = 0;   // model of the round-robin pointer

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every response handshake pops and compares one scoreboard entry
    always @(negedge CLK) begin
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("mon_id",   32'(rsp_id), 32'(e.id));
                chk("mon_data", rsp_data,    e.data);
                chk("mon_err",  32'(rsp_err), 32'(e.err));
            end
        end
    end

    // One complete operation. d = WAIT cycle (1-based) carrying core_done;
    // d > TIMEOUT means the core never answers in time.
    task automatic txn(input logic [3:0] pat, input int stall, input int d,
                       input int bp, input bit do_rst, input bit use_one);
        logic [31:0] dat [4];
        logic [31:0] res;
        logic [31:0] exp_data;
        logic        exp_err;
        int          w;
        int          nwait;
        rsp_t        e;

        for (int i = 0; i < 4; i++) dat[i] = $urandom;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && pat[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
        end
        if (use_one) dat[w] = 32'h3F800000;
        res      = (dat[w] == 32'h3F800000) ? 32'h402DF854 : $urandom;
        exp_err  = (d > TIMEOUT);
        exp_data = exp_err ? 32'h0 : res;
        if (!do_rst) begin
            e.id = 2'(w); e.data = exp_data; e.err = exp_err;
            sb.push_back(e);
        end

        // IDLE: offer operands
        req_valid = pat;
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = dat[i];
        rsp_ready        = 1'b0;
        core_input_ready = 1'b0;
        core_done        = 1'b0;
        @(negedge CLK);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("grant", 32'(req_ready), 32'(4'd1 << w));
        tick();

        // LOAD, with optional stall; stray done pulses must be ignored
        req_valid = pat & ~(4'd1 << w);
        for (int k = 0; k <= stall; k++) begin
            core_input_ready = (k == stall);
            core_done        = 1'($urandom_range(0, 1));
            core_result      = $urandom;
            @(negedge CLK);
            chk("load_core_load", 32'(core_load), 32'd1);
            chk("load_operand", core_operand, dat[w]);
            chk("load_req_ready", 32'(req_ready), 32'd0);
            chk("load_core_start", 32'(core_start), 32'd0);
            tick();
        end
        core_input_ready = 1'b0;

        // WAIT
        nwait = do_rst ? 3 : ((d <= TIMEOUT) ? d : TIMEOUT);
        for (int j = 1; j <= nwait; j++) begin
            core_done   = (j == d);
            core_result = (j == d) ? res : $urandom;
            @(negedge CLK);
            chk("wait_core_start", 32'(core_start), 32'd1);
            chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        core_done = 1'b0;

        if (do_rst) begin
            req_valid = '0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            @(negedge CLK);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_core_load", 32'(core_load), 32'd0);
            chk("rst_core_start", 32'(core_start), 32'd0);
            ptr_m = 0;
            tick();
            return;
        end

        // RESP with backpressure
        for (int b = 0; b < bp; b++) begin
            core_done   = 1'($urandom_range(0, 1));
            core_result = $urandom;
            @(negedge CLK);
            chk("resp_valid", 32'(rsp_valid), 32'd1);
            chk("resp_id", 32'(rsp_id), 32'(w));
            chk("resp_data", rsp_data, exp_data);
            chk("resp_err", 32'(rsp_err), 32'(exp_err));
            chk("resp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        core_done = 1'b0;
        rsp_ready = 1'b1;
        @(negedge CLK);
        chk("resp_valid_hs", 32'(rsp_valid), 32'd1);
        tick();
        rsp_ready = 1'b0;
        req_valid = '0;
        ptr_m     = (w + 1) % 4;
        @(negedge CLK);
        chk("idle_after_rsp", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        rst              = 1'b1;
        req_valid        = '0;
        req_data         = '0;
        core_input_ready = 1'b0;
        core_done        = 1'b0;
        core_result      = '0;
        rsp_ready        = 1'b0;
        tick();
        @(negedge CLK);
        chk("rst_busy_during", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge CLK);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_core_load", 32'(core_load), 32'd0);
        chk("reset_core_start", 32'(core_start), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_operand", core_operand, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // Single request of 1.0 from requester 1
        txn(4'b0010, 0, 4, 0, 1'b0, 1'b1);
        // Pointer now at 2; reset while waiting drops the op and zeroes ptr
        txn(4'b1111, 0, TIMEOUT + 5, 0, 1'b1, 1'b0);
        // Round robin from ptr 0: 0,1,2,3,0
        for (int i = 0; i < 5; i++) txn(4'b1111, 0, 1 + (i % 3), 0, 1'b0, 1'b0);
        // Load stall of 5 cycles
        txn(4'b0100, 5, 2, 0, 1'b0, 1'b0);
        // Timeout, then done exactly on the timeout cycle
        txn(4'b1001, 0, TIMEOUT + 3, 0, 1'b0, 1'b0);
        txn(4'b0110, 0, TIMEOUT, 0, 1'b0, 1'b0);
        // Response backpressure for 10 cycles with others pending
        txn(4'b1111, 1, 3, 10, 1'b0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            txn(4'($urandom_range(1, 15)), $urandom_range(0, 3),
                $urandom_range(1, TIMEOUT + 4), $urandom_range(0, 4), 1'b0, 1'b0);
        end

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
